mem_wb_stage: RTL

//   MEM/WB pipeline register plus write-back stage of the 5-stage RV32I core. Captures the MEM

---
 rtl/mem_wb_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage: load alignment/extension, write-back mux,
// register-file write port, forwarding bus, misaligned-load flag and retired-instruction counter.
module mem_wb_stage #(
  parameter int CNT_W = 64
) (
  input  logic             sys_clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      alu_result_i,
  input  logic [4:0]       rd_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic [2:0]       funct3_i,
  input  logic [31:0]      DM_rd_data_i,
  output logic             rf_wr_en_o,
  output logic [4:0]       rf_wr_addr_o,
  output logic [31:0]      rf_wr_data_o,
  output logic             fwd_valid_o,
  output logic [4:0]       fwd_rd_o,
  output logic [31:0]      fwd_data_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] instret_o
);

  logic             valid_q;
  logic             first_q;
  logic             RegWrite_q;
  logic             MemtoReg_q;
  logic [31:0]      alu_q;
  logic [4:0]       rd_q;
  logic [2:0]       funct3_q;
  logic [31:0]      ld_hold;
  logic [CNT_W-1:0] instret_q;

  logic             retire;
  logic [31:0]      ld_word;
  logic [7:0]       ld_lane [4];
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_ext;
  logic             misalign;
  logic [31:0]      wb_data;
  logic             wr_ok;

  assign retire = valid_q & first_q;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      RegWrite_q <= 1'b0;
      MemtoReg_q <= 1'b0;
      alu_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      ld_hold    <= '0;
      instret_q  <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
        first_q <= 1'b0;
      end else if (stall_i) begin
        first_q <= 1'b0;
      end else begin
        valid_q    <= valid_i;
        first_q    <= valid_i;
        alu_q      <= alu_result_i;
        rd_q       <= rd_i;
        RegWrite_q <= RegWrite_i;
        MemtoReg_q <= MemtoReg_i;
        funct3_q   <= funct3_i;
      end
      // Memory output is only guaranteed in the first WB cycle; keep it for stalled cycles.
      if (first_q) begin
        ld_hold <= DM_rd_data_i;
      end
      if (retire) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  assign ld_word = first_q ? DM_rd_data_i : ld_hold;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign ld_lane[gi] = ld_word[8*gi +: 8];
    end
  endgenerate

  assign ld_byte = ld_lane[alu_q[1:0]];
  assign ld_half = alu_q[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_ext   = ld_word;
    misalign = 1'b0;
    case (funct3_q)
      3'b000: ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_ext = {24'd0, ld_byte};
      3'b001: begin
        ld_ext   = {{16{ld_half[15]}}, ld_half};
        misalign = alu_q[0];
      end
      3'b101: begin
        ld_ext   = {16'd0, ld_half};
        misalign = alu_q[0];
      end
      default: misalign = |alu_q[1:0];
    endcase
    if (!MemtoReg_q) begin
      misalign = 1'b0;
    end
  end

  assign wb_data = MemtoReg_q ? ld_ext : alu_q;
  assign wr_ok   = valid_q & RegWrite_q & (rd_q != 5'd0) & ~misalign;

  assign rf_wr_en_o   = first_q & wr_ok;
  assign rf_wr_addr_o = rd_q;
  assign rf_wr_data_o = wb_data;
  assign fwd_valid_o  = wr_ok;
  assign fwd_rd_o     = rd_q;
  assign fwd_data_o   = wb_data;
  assign misalign_o   = retire & misalign;
  assign instret_o    = instret_q;

endmodule
